// File: rtl/msg_padder_pkg.sv
// Shared definitions for the SHA-2 message padder: SHA type codes, block and
// length-field sizes, FSM/extra-block encodings and a byte-lane popcount.
package msg_padder_pkg;

  typedef enum logic [1:0] {
    SHA224 = 2'd0,
    SHA256 = 2'd1,
    SHA384 = 2'd2,
    SHA512 = 2'd3
  } sha_type_e;

  localparam int         BUF_BYTES   = 128;
  localparam logic [7:0] BLK_B_SHORT = 8'd64;
  localparam logic [7:0] BLK_B_LONG  = 8'd128;
  localparam logic [7:0] LEN_L_SHORT = 8'd8;
  localparam logic [7:0] LEN_L_LONG  = 8'd16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PAD,
    ST_SEND
  } state_e;

  typedef enum logic [1:0] {
    EX_NONE,
    EX_LEN_ONLY,
    EX_MARK_LEN
  } extra_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/msg_padder_buf.sv
// 128-byte padding buffer: keyed 8-lane writes, 0x80 marker, big-endian
// length field, clear, and 512-bit beat read-out.
module pad_block_buf
  import msg_padder_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         wr_en_i,
  input  logic [6:0]   wr_ptr_i,
  input  logic [63:0]  wr_data_i,
  input  logic [7:0]   wr_keep_i,
  input  logic         mark_en_i,
  input  logic [6:0]   mark_ptr_i,
  input  logic         len_en_i,
  input  logic [6:0]   len_base_i,
  input  logic [63:0]  len_bits_i,
  input  logic         beat_sel_i,
  output logic [511:0] beat_o
);

  logic [BUF_BYTES-1:0][7:0] buf_q;

  // Writes follow the clear so an extra block can be cleared and rebuilt
  // in the same cycle if ever required.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else begin
      if (clr_i) buf_q <= '0;
      if (wr_en_i)
        for (int i = 0; i < 8; i++)
          if (wr_keep_i[i]) buf_q[wr_ptr_i + 7'(i)] <= wr_data_i[8*i +: 8];
      if (mark_en_i) buf_q[mark_ptr_i] <= 8'h80;
      if (len_en_i)
        for (int i = 0; i < 8; i++) buf_q[len_base_i + 7'(i)] <= len_bits_i[63-8*i -: 8];
    end
  end

  assign beat_o = beat_sel_i ? buf_q[127:64] : buf_q[63:0];

endmodule

// File: rtl/msg_padder.sv
// SHA-2 front end: collects a 64-bit AXI-Stream message, applies FIPS 180-4
// padding and streams 512-bit block beats to the schedule unit.
module msg_padder
  import msg_padder_pkg::*;
#(
  parameter int S_AXIS_DATA_WIDTH = 64,
  parameter int M_AXIS_DATA_WIDTH = 512,
  parameter int LEN_CNT_WIDTH     = 61
) (
  input  logic                         axi_aclk,
  input  logic                         axi_resetn,
  input  logic [1:0]                   sha_type,
  input  logic                         en,
  output logic                         busy,
  input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [7:0]                   s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);

  state_e                   state_q, state_d;
  extra_e                   extra_q, extra_d;
  logic [1:0]               sha_q, sha_d;
  logic [7:0]               ptr_q, ptr_d;
  logic [LEN_CNT_WIDTH-1:0] len_q, len_d;
  logic                     last_blk_q, last_blk_d;
  logic                     beat_q, beat_d;
  logic                     build_q, build_d;

  logic       clr, wr_en, mark_en, len_en;
  logic [6:0] mark_ptr, len_base;
  logic [7:0] wr_keep, blk_b, len_l, pad_lim;
  logic [3:0] n_bytes;
  logic [63:0] len_bits;

  assign blk_b    = sha_q[1] ? BLK_B_LONG : BLK_B_SHORT;
  assign len_l    = sha_q[1] ? LEN_L_LONG : LEN_L_SHORT;
  assign pad_lim  = blk_b - len_l - 8'd1;
  assign len_base = 7'(blk_b - 8'd8);
  assign n_bytes  = popcount8(s_axis_tkeep);
  assign len_bits = 64'({len_q, 3'b000});

  assign busy         = (state_q != ST_IDLE);
  assign m_axis_tlast = m_axis_tvalid & last_blk_q;

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q    <= ST_IDLE;
      extra_q    <= EX_NONE;
      sha_q      <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      last_blk_q <= 1'b0;
      beat_q     <= 1'b0;
      build_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      extra_q    <= extra_d;
      sha_q      <= sha_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      last_blk_q <= last_blk_d;
      beat_q     <= beat_d;
      build_q    <= build_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    extra_d       = extra_q;
    sha_d         = sha_q;
    ptr_d         = ptr_q;
    len_d         = len_q;
    last_blk_d    = last_blk_q;
    beat_d        = beat_q;
    build_d       = build_q;
    clr           = 1'b0;
    wr_en         = 1'b0;
    wr_keep       = 8'hFF;
    mark_en       = 1'b0;
    mark_ptr      = ptr_q[6:0];
    len_en        = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    unique case (state_q)
      ST_IDLE: if (en) begin
        sha_d      = sha_type;
        clr        = 1'b1;
        ptr_d      = '0;
        len_d      = '0;
        last_blk_d = 1'b0;
        extra_d    = EX_NONE;
        beat_d     = 1'b0;
        build_d    = 1'b0;
        state_d    = ST_FILL;
      end
      ST_FILL: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          wr_en = 1'b1;
          if (s_axis_tlast) begin
            wr_keep = 8'((9'd1 << n_bytes) - 9'd1);
            ptr_d   = ptr_q + {4'b0000, n_bytes};
            len_d   = len_q + {{(LEN_CNT_WIDTH-4){1'b0}}, n_bytes};
            state_d = ST_PAD;
          end else begin
            ptr_d = ptr_q + 8'd8;
            len_d = len_q + LEN_CNT_WIDTH'(8);
            if (ptr_q + 8'd8 == blk_b) begin
              last_blk_d = 1'b0;
              extra_d    = EX_NONE;
              beat_d     = 1'b0;
              state_d    = ST_SEND;
            end
          end
        end
      end
      // ptr_q now holds the pad pointer (first byte after the message tail).
      ST_PAD: begin
        beat_d  = 1'b0;
        state_d = ST_SEND;
        if (ptr_q <= pad_lim) begin
          mark_en    = 1'b1;
          len_en     = 1'b1;
          last_blk_d = 1'b1;
          extra_d    = EX_NONE;
        end else if (ptr_q < blk_b) begin
          mark_en    = 1'b1;
          last_blk_d = 1'b0;
          extra_d    = EX_LEN_ONLY;
        end else begin
          last_blk_d = 1'b0;
          extra_d    = EX_MARK_LEN;
        end
      end
      ST_SEND: begin
        if (build_q) begin
          len_en     = 1'b1;
          mark_en    = (extra_q == EX_MARK_LEN);
          mark_ptr   = '0;
          last_blk_d = 1'b1;
          extra_d    = EX_NONE;
          build_d    = 1'b0;
        end else begin
          m_axis_tvalid = 1'b1;
          if (m_axis_tready) begin
            if (beat_q == sha_q[1]) begin
              clr    = 1'b1;
              ptr_d  = '0;
              beat_d = 1'b0;
              if (last_blk_q)              state_d = ST_IDLE;
              else if (extra_q != EX_NONE) build_d = 1'b1;
              else                         state_d = ST_FILL;
            end else begin
              beat_d = 1'b1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  pad_block_buf u_buf (
    .clk        (axi_aclk),
    .rst_n      (axi_resetn),
    .clr_i      (clr),
    .wr_en_i    (wr_en),
    .wr_ptr_i   (ptr_q[6:0]),
    .wr_data_i  (s_axis_tdata),
    .wr_keep_i  (wr_keep),
    .mark_en_i  (mark_en),
    .mark_ptr_i (mark_ptr),
    .len_en_i   (len_en),
    .len_base_i (len_base),
    .len_bits_i (len_bits),
    .beat_sel_i (beat_q),
    .beat_o     (m_axis_tdata)
  );

endmodule

// File: tb/tb_msg_padder.sv
// Bench for msg_padder: directed FIPS 180-4 vectors plus randomized messages
// checked against a byte-queue padding model.
module tb_msg_padder;
  logic         axi_aclk = 1'b0;
  logic         axi_resetn;
  logic [1:0]   sha_type;
  logic         en, busy;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic         s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [511:0] m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;

  localparam int LIMIT = 3000;

  int n_checks = 0, n_pass = 0, cyc = 0;
  byte unsigned msg[$];
  logic [511:0] exp_d[$], got_d[$];
  bit           exp_l[$], got_l[$];
  int hs_cyc, tv_cyc, stall_bad;
  bit drv_to, col_to, stall_done, tail_empty, gaps;

  msg_padder dut (
    .axi_aclk(axi_aclk), .axi_resetn(axi_resetn), .sha_type(sha_type), .en(en), .busy(busy),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #5 axi_aclk = ~axi_aclk;
  always @(posedge axi_aclk) cyc <= cyc + 1;

  // Reference: append 0x80, zero-fill to B-L mod B, append L-byte big-endian bit length.
  task automatic build_model(input logic [1:0] sha);
    byte unsigned p[$];
    int B, L, nblk;
    longint unsigned bits;
    logic [511:0] d;
    B = sha[1] ? 128 : 64;
    L = sha[1] ? 16 : 8;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while ((p.size() % B) != B - L) p.push_back(8'h00);
    for (int i = 0; i < L; i++)
      p.push_back((i < L - 8) ? 8'h00 : 8'(bits >> (8 * (L - 1 - i))));
    nblk = p.size() / B;
    exp_d.delete(); exp_l.delete();
    for (int blk = 0; blk < nblk; blk++)
      for (int bt = 0; bt < B / 64; bt++) begin
        for (int k = 0; k < 64; k++) d[8*k +: 8] = p[blk*B + bt*64 + k];
        exp_d.push_back(d);
        exp_l.push_back(blk == nblk - 1);
      end
  endtask

  task automatic start_msg(input logic [1:0] sha);
    @(negedge axi_aclk);
    sha_type = sha; en = 1'b1;
    @(negedge axi_aclk);
    en = 1'b0; sha_type = 2'($urandom);
  endtask

  task automatic drive_msg();
    int len, nb, tot, nbytes;
    bit extra_tail, last;
    len = msg.size();
    nb = (len + 7) / 8;
    extra_tail = (nb == 0) || (tail_empty && (len % 8 == 0));
    tot = nb + (extra_tail ? 1 : 0);
    drv_to = 1'b0;
    for (int b = 0; b < tot; b++) begin
      last = (b == tot - 1);
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_axis_tvalid = 1'b0;
        @(negedge axi_aclk);
      end
      s_axis_tdata = {$urandom, $urandom};
      nbytes = (b < nb) ? (((len - 8*b) < 8) ? (len - 8*b) : 8) : 0;
      for (int k = 0; k < nbytes; k++) s_axis_tdata[8*k +: 8] = msg[8*b + k];
      s_axis_tkeep  = last ? 8'((9'd1 << nbytes) - 9'd1) : 8'($urandom);
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      if (gaps) begin en = 1'($urandom_range(0, 1)); sha_type = 2'($urandom); end
      for (int w = 0; w < LIMIT && !s_axis_tready; w++) @(negedge axi_aclk);
      if (!s_axis_tready) begin drv_to = 1'b1; break; end
      if (last) hs_cyc = cyc;
      @(negedge axi_aclk);
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; en = 1'b0;
  endtask

  task automatic collect(input int n, input bit stall, input bit rr);
    logic [511:0] snap;
    bit snapl;
    int cnt;
    cnt = 0;
    got_d.delete(); got_l.delete();
    tv_cyc = -1; stall_bad = 0; stall_done = 1'b0; col_to = 1'b0;
    while (got_d.size() < n && cnt < LIMIT) begin
      if (stall && !stall_done && m_axis_tvalid) begin
        m_axis_tready = 1'b0; snap = m_axis_tdata; snapl = m_axis_tlast;
        for (int s = 0; s < 5; s++) begin
          @(negedge axi_aclk);
          if (m_axis_tdata !== snap || m_axis_tvalid !== 1'b1 || m_axis_tlast !== snapl ||
              s_axis_tready !== 1'b0) stall_bad++;
        end
        stall_done = 1'b1;
      end
      m_axis_tready = rr ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (m_axis_tvalid && tv_cyc < 0) tv_cyc = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
        got_d.push_back(m_axis_tdata);
        got_l.push_back(m_axis_tlast);
      end
      @(negedge axi_aclk);
      cnt++;
    end
    if (got_d.size() < n) col_to = 1'b1;
    m_axis_tready = 1'b1;
  endtask

  task automatic run_msg(input logic [1:0] sha, input bit g, input bit tail, input bit stall, input bit rr);
    build_model(sha);
    gaps = g; tail_empty = tail;
    start_msg(sha);
    fork
      drive_msg();
      collect(exp_d.size(), stall, rr);
    join
  endtask

  task automatic fill_random(input int len);
    msg.delete();
    for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    axi_resetn = 1'b0; en = 1'b0; sha_type = '0; s_axis_tdata = '0; s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
    repeat (3) @(negedge axi_aclk);
    n_checks++;
    if ({busy, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 4'b0 || m_axis_tdata !== '0)
      $display("FAIL reset_state: busy=%b s_rdy=%b m_vld=%b m_last=%b tdata_nonzero=%b required all 0",
               busy, s_axis_tready, m_axis_tvalid, m_axis_tlast, |m_axis_tdata);
    else n_pass++;
    axi_resetn = 1'b1;
    @(negedge axi_aclk);
  endtask

  task automatic test_abc256();
    logic [511:0] e;
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    e = '0; e[31:0] = 32'h80636261; e[511:504] = 8'h18;
    n_checks++;
    if (got_d.size() != 1 || drv_to || col_to)
      $display("FAIL abc256_count: got %0d beats (to=%b/%b) required 1", got_d.size(), drv_to, col_to);
    else begin
      n_pass++;
      n_checks++;
      if (got_d[0] !== e || got_l[0] !== 1'b1)
        $display("FAIL abc256_data: got %h last=%b required %h last=1", got_d[0], got_l[0], e);
      else n_pass++;
    end
    n_checks++;
    if (tv_cyc - hs_cyc != 2) $display("FAIL abc256_latency: got %0d cycles required 2", tv_cyc - hs_cyc);
    else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL abc256_idle: busy=%b required 0", busy);
    else n_pass++;
  endtask

  task automatic test_empty();
    logic [511:0] e;
    msg.delete();
    run_msg(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    e = '0; e[7:0] = 8'h80;
    n_checks++;
    if (got_d.size() != 1 || col_to || got_d[0] !== e || got_l[0] !== 1'b1)
      $display("FAIL empty_msg: beats=%0d data=%h required 1 beat %h last=1", got_d.size(),
               (got_d.size() > 0) ? got_d[0] : 512'h0, e);
    else n_pass++;
  endtask

  task automatic test_56();
    logic [511:0] e1, e2;
    fill_random(56);
    run_msg(2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    e1 = '0;
    for (int k = 0; k < 56; k++) e1[8*k +: 8] = msg[k];
    e1[8*56 +: 8] = 8'h80;
    e2 = '0; e2[8*62 +: 8] = 8'h01; e2[8*63 +: 8] = 8'hC0;
    n_checks++;
    if (got_d.size() != 2 || col_to) $display("FAIL len56_count: got %0d beats required 2", got_d.size());
    else begin
      n_pass++;
      n_checks++;
      if (got_d[0] !== e1 || got_l[0] !== 1'b0)
        $display("FAIL len56_blk1: got %h last=%b required %h last=0", got_d[0], got_l[0], e1);
      else n_pass++;
      n_checks++;
      if (got_d[1] !== e2 || got_l[1] !== 1'b1)
        $display("FAIL len56_blk2: got %h last=%b required %h last=1", got_d[1], got_l[1], e2);
      else n_pass++;
    end
  endtask

  task automatic test_64();
    logic [511:0] e1, e2;
    for (int tail = 0; tail < 2; tail++) begin
      fill_random(64);
      run_msg(2'd1, 1'b0, 1'(tail), 1'b0, 1'b0);
      e1 = '0;
      for (int k = 0; k < 64; k++) e1[8*k +: 8] = msg[k];
      e2 = '0; e2[7:0] = 8'h80; e2[8*62 +: 8] = 8'h02;
      n_checks++;
      if (got_d.size() != 2 || col_to)
        $display("FAIL len64_count tail=%0d: got %0d beats required 2", tail, got_d.size());
      else begin
        n_pass++;
        n_checks++;
        if (got_d[0] !== e1 || got_l[0] !== 1'b0 || got_d[1] !== e2 || got_l[1] !== 1'b1)
          $display("FAIL len64_blocks tail=%0d: got %h/%h last=%b%b required %h/%h last=01", tail,
                   got_d[0], got_d[1], got_l[0], got_l[1], e1, e2);
        else n_pass++;
      end
    end
  endtask

  task automatic test_abc512();
    logic [511:0] e0, e1;
    msg = '{8'h61, 8'h62, 8'h63};
    run_msg(2'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    e0 = '0; e0[31:0] = 32'h80636261;
    e1 = '0; e1[511:504] = 8'h18;
    n_checks++;
    if (got_d.size() != 2 || col_to) $display("FAIL abc512_count: got %0d beats required 2", got_d.size());
    else begin
      n_pass++;
      n_checks++;
      if (got_d[0] !== e0 || got_d[1] !== e1 || got_l[0] !== 1'b1 || got_l[1] !== 1'b1)
        $display("FAIL abc512_data: got %h/%h last=%b%b required %h/%h last=11",
                 got_d[0], got_d[1], got_l[0], got_l[1], e0, e1);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    for (int s = 0; s < 4; s++) begin
      fill_random($urandom_range(20, 150));
      run_msg(2'(s), 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (!stall_done || stall_bad != 0)
        $display("FAIL stall_hold sha=%0d: done=%b unstable_cycles=%0d required done=1 unstable=0",
                 s, stall_done, stall_bad);
      else n_pass++;
      n_checks++;
      if (got_d != exp_d || got_l != exp_l || col_to)
        $display("FAIL stall_data sha=%0d: got %0d beats required %0d matching model", s,
                 got_d.size(), exp_d.size());
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_fill();
    for (int s = 0; s < 4; s++) begin
      start_msg(2'(s));
      for (int b = 0; b < 3; b++) begin
        s_axis_tdata = {$urandom, $urandom}; s_axis_tkeep = 8'hFF;
        s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        @(negedge axi_aclk);
      end
      axi_resetn = 1'b0;
      #1;
      n_checks++;
      if ({busy, s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 4'b0 || m_axis_tdata !== '0)
        $display("FAIL reset_mid_fill sha=%0d: busy=%b s_rdy=%b m_vld=%b m_last=%b required all 0",
                 s, busy, s_axis_tready, m_axis_tvalid, m_axis_tlast);
      else n_pass++;
      s_axis_tvalid = 1'b0;
      @(negedge axi_aclk);
      axi_resetn = 1'b1;
      fill_random($urandom_range(0, 140));
      run_msg(2'(s), 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (got_d != exp_d || got_l != exp_l || col_to || drv_to)
        $display("FAIL reset_restart sha=%0d: got %0d beats required %0d matching model", s,
                 got_d.size(), exp_d.size());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int edges[13] = '{0, 55, 56, 57, 63, 64, 65, 111, 112, 119, 120, 127, 128};
    int len;
    logic [1:0] sha;
    for (int t = 0; t < 40; t++) begin
      sha = 2'($urandom);
      len = ($urandom_range(0, 1) == 0) ? edges[$urandom_range(0, 12)] : int'($urandom_range(0, 300));
      fill_random(len);
      run_msg(sha, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      n_checks++;
      if (got_d.size() != exp_d.size() || drv_to || col_to)
        $display("FAIL rand_count t=%0d sha=%0d len=%0d: got %0d beats required %0d", t, sha, len,
                 got_d.size(), exp_d.size());
      else n_pass++;
      for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
        n_checks++;
        if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i])
          $display("FAIL rand_beat t=%0d beat=%0d: got %h last=%b required %h last=%b", t, i,
                   got_d[i], got_l[i], exp_d[i], exp_l[i]);
        else n_pass++;
      end
      n_checks++;
      if (busy !== 1'b0) $display("FAIL rand_idle t=%0d: busy=%b required 0", t, busy);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_abc256();
    test_empty();
    test_56();
    test_64();
    test_abc512();
    test_stall();
    test_reset_mid_fill();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
